// File: rtl/seg_scan_decoder.sv
// Recovers BCD digits from a scanned, active-low seven-segment bus: per-sample debounce,
// segment decode and in-order assembly of NUM_DIGITS digits into a frame.
module seg_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   digit_sel,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic                    frame_valid,
    output logic                    frame_err,
    output logic                    sync_err
);

    localparam int         EW     = $clog2(NUM_DIGITS) + 1;
    localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

    typedef enum logic {SYNC, COLLECT} state_t;

    state_t                       state, state_n;
    logic [6:0]                   s_seg;
    logic [NUM_DIGITS-1:0]        s_sel;
    logic [3:0]                   stab_cnt, stab_n;
    logic                         same, acc, acc_n;
    logic [EW-1:0]                expect_q, expect_n;
    logic                         err_acc, err_n;
    logic [NUM_DIGITS-1:0][3:0]   shadow, shadow_n, bcd_q, bcd_n, with_new;
    logic                         fv_n, fe_n, se_n;
    logic [4:0]                   dec;
    logic [3:0]                   dig;
    logic                         inv, multi, first, match, last;

    // {invalid, bcd}; unknown patterns decode to F and flag the frame
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h40:   decode = 5'h00;
            7'h79:   decode = 5'h01;
            7'h24:   decode = 5'h02;
            7'h30:   decode = 5'h03;
            7'h19:   decode = 5'h04;
            7'h12:   decode = 5'h05;
            7'h02:   decode = 5'h06;
            7'h78:   decode = 5'h07;
            7'h00:   decode = 5'h08;
            7'h18:   decode = 5'h09;
            default: decode = 5'h1F;
        endcase
    endfunction

    // Incoming sample is compared against the one already held in s_*, so the counter
    // reaches 1 on the edge that first captures a value and the accept is registered
    // alongside the s_* copy it refers to.
    assign same = ({seg_in, digit_sel} == {s_seg, s_sel});

    always_comb begin
        stab_n = 4'd1;
        if (same)
            stab_n = (stab_cnt >= STABLE) ? STABLE : stab_cnt + 4'd1;
        acc_n = (stab_n == STABLE) && (!same || stab_cnt != STABLE);
    end

    assign dec   = decode(s_seg);
    assign dig   = dec[3:0];
    assign inv   = dec[4];
    assign multi = (s_sel & (s_sel - NUM_DIGITS'(1))) != '0;
    assign first = (s_sel == NUM_DIGITS'(1));
    assign match = (s_sel == (NUM_DIGITS'(1) << expect_q));
    assign last  = (expect_q == EW'(NUM_DIGITS - 1));

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++)
            with_new[i] = (expect_q == EW'(i)) ? dig : shadow[i];
    end

    always_comb begin
        state_n  = state;
        shadow_n = shadow;
        err_n    = err_acc;
        expect_n = expect_q;
        bcd_n    = bcd_q;
        fv_n     = 1'b0;
        fe_n     = 1'b0;
        se_n     = 1'b0;
        if (acc && s_sel != '0) begin
            if (multi) begin
                se_n     = 1'b1;
                state_n  = SYNC;
                shadow_n = '0;
                err_n    = 1'b0;
                expect_n = '0;
            end else if (state == SYNC) begin
                if (first) begin
                    if (NUM_DIGITS == 1) begin
                        bcd_n    = shadow;
                        bcd_n[0] = dig;
                        fv_n     = 1'b1;
                        fe_n     = inv;
                    end else begin
                        shadow_n    = '0;
                        shadow_n[0] = dig;
                        err_n       = inv;
                        expect_n    = EW'(1);
                        state_n     = COLLECT;
                    end
                end
            end else if (match) begin
                if (last) begin
                    bcd_n    = with_new;
                    fv_n     = 1'b1;
                    fe_n     = err_acc | inv;
                    state_n  = SYNC;
                    shadow_n = '0;
                    err_n    = 1'b0;
                    expect_n = '0;
                end else begin
                    shadow_n = with_new;
                    err_n    = err_acc | inv;
                    expect_n = expect_q + EW'(1);
                end
            end else if (first) begin
                // digit 0 mid-frame: treat as the start of a fresh frame
                se_n        = 1'b1;
                shadow_n    = '0;
                shadow_n[0] = dig;
                err_n       = inv;
                expect_n    = EW'(1);
            end else begin
                se_n     = 1'b1;
                state_n  = SYNC;
                shadow_n = '0;
                err_n    = 1'b0;
                expect_n = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= SYNC;
            s_seg       <= '0;
            s_sel       <= '0;
            stab_cnt    <= '0;
            acc         <= 1'b0;
            shadow      <= '0;
            err_acc     <= 1'b0;
            expect_q    <= '0;
            bcd_q       <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            state       <= state_n;
            s_seg       <= seg_in;
            s_sel       <= digit_sel;
            stab_cnt    <= stab_n;
            acc         <= acc_n;
            shadow      <= shadow_n;
            err_acc     <= err_n;
            expect_q    <= expect_n;
            bcd_q       <= bcd_n;
            frame_valid <= fv_n;
            frame_err   <= fe_n;
            sync_err    <= se_n;
        end
    end

    assign bcd_out = bcd_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder (4 digits, 2-sample debounce): ordered scans,
// glitches, bad patterns, sequencing errors, blanking, restarts and mid-frame reset.
module tb_seg_scan_decoder;

    localparam logic [6:0] BLANK = 7'h7F;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [6:0]  seg_in;
    logic [3:0]  digit_sel;
    logic [15:0] bcd_out;
    logic        frame_valid, frame_err, sync_err;

    int   total = 0;
    int   bad = 0;
    int   fv_cnt = 0;
    int   se_cnt = 0;
    int   both = 0;
    logic last_fe = 1'b0;

    seg_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(2)) dut (
        .clk(clk), .n_rst(n_rst), .seg_in(seg_in), .digit_sel(digit_sel),
        .bcd_out(bcd_out), .frame_valid(frame_valid), .frame_err(frame_err),
        .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    // pulse bookkeeping, sampled mid-cycle
    always @(negedge clk) begin
        if (frame_valid) begin
            fv_cnt  = fv_cnt + 1;
            last_fe = frame_err;
        end
        if (sync_err) se_cnt = se_cnt + 1;
        if (frame_valid && sync_err) both = both + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic show(input logic [6:0] s, input logic [3:0] sel, input int n);
        @(negedge clk);
        seg_in    = s;
        digit_sel = sel;
        repeat (n) @(posedge clk);
    endtask

    task automatic scan4(input logic [6:0] a, input logic [6:0] b,
                         input logic [6:0] c, input logic [6:0] d);
        show(a, 4'b0001, 3);
        show(b, 4'b0010, 3);
        show(c, 4'b0100, 3);
        show(d, 4'b1000, 3);
        show(BLANK, 4'b0000, 3);
    endtask

    initial begin
        n_rst     = 1'b0;
        seg_in    = BLANK;
        digit_sel = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bcd", 32'(bcd_out), 32'h0);
        chk("rst_fv", 32'(frame_valid), 32'h0);
        chk("rst_fe", 32'(frame_err), 32'h0);
        chk("rst_se", 32'(sync_err), 32'h0);
        @(negedge clk);
        n_rst = 1'b1;

        // 1: clean scan, exact completion latency
        show(7'h79, 4'b0001, 3);
        show(7'h24, 4'b0010, 3);
        show(7'h30, 4'b0100, 3);
        show(7'h19, 4'b1000, 3);
        #1;
        chk("t1_fv_edge", 32'(frame_valid), 32'h1);
        chk("t1_bcd", 32'(bcd_out), 32'h4321);
        chk("t1_fe", 32'(frame_err), 32'h0);
        show(BLANK, 4'b0000, 3);
        #1;
        chk("t1_fv_low", 32'(frame_valid), 32'h0);
        chk("t1_fv_cnt", 32'(fv_cnt), 32'd1);

        // 2: one-sample glitch on digit 2 is rejected
        show(7'h79, 4'b0001, 3);
        show(7'h24, 4'b0010, 3);
        show(7'h7F, 4'b0100, 1);
        show(7'h30, 4'b0100, 3);
        show(7'h19, 4'b1000, 3);
        show(BLANK, 4'b0000, 3);
        chk("t2_bcd", 32'(bcd_out), 32'h4321);
        chk("t2_fv_cnt", 32'(fv_cnt), 32'd2);
        chk("t2_fe", 32'(last_fe), 32'h0);
        chk("t2_se_cnt", 32'(se_cnt), 32'd0);

        // 3: undecodable digit 1
        scan4(7'h79, 7'h7F, 7'h30, 7'h19);
        chk("t3_bcd", 32'(bcd_out), 32'h43F1);
        chk("t3_fe_pulse", 32'(last_fe), 32'h1);
        chk("t3_fv_cnt", 32'(fv_cnt), 32'd3);
        chk("t3_fe_idle", 32'(frame_err), 32'h0);

        // 4: out-of-order select aborts, then a clean frame
        show(7'h79, 4'b0001, 3);
        show(7'h24, 4'b0010, 3);
        show(7'h19, 4'b1000, 3);
        show(BLANK, 4'b0000, 3);
        chk("t4_se_cnt", 32'(se_cnt), 32'd1);
        chk("t4_no_fv", 32'(fv_cnt), 32'd3);
        chk("t4_bcd_hold", 32'(bcd_out), 32'h43F1);
        scan4(7'h12, 7'h02, 7'h78, 7'h00);
        chk("t4_bcd", 32'(bcd_out), 32'h8765);
        chk("t4_fv_cnt", 32'(fv_cnt), 32'd4);

        // 5: blanks between digits ignored; digit 0 mid-frame restarts
        show(7'h18, 4'b0001, 3);
        show(BLANK, 4'b0000, 3);
        show(7'h79, 4'b0010, 3);
        show(BLANK, 4'b0000, 2);
        chk("t5_blank_se", 32'(se_cnt), 32'd1);
        show(7'h24, 4'b0001, 3);
        show(BLANK, 4'b0000, 3);
        chk("t5_restart_se", 32'(se_cnt), 32'd2);
        show(7'h40, 4'b0010, 3);
        show(7'h18, 4'b0100, 3);
        show(7'h78, 4'b1000, 3);
        show(BLANK, 4'b0000, 3);
        chk("t5_bcd", 32'(bcd_out), 32'h7902);
        chk("t5_fv_cnt", 32'(fv_cnt), 32'd5);
        chk("t5_se_cnt", 32'(se_cnt), 32'd2);

        // 6: multi-hot select
        show(7'h79, 4'b0001, 3);
        show(7'h24, 4'b0110, 3);
        show(BLANK, 4'b0000, 3);
        chk("t6_multi_se", 32'(se_cnt), 32'd3);
        chk("t6_multi_fv", 32'(fv_cnt), 32'd5);

        // 7: reset in the middle of a frame
        scan4(7'h79, 7'h24, 7'h30, 7'h19);
        chk("t7_pre_bcd", 32'(bcd_out), 32'h4321);
        show(7'h79, 4'b0001, 3);
        show(7'h24, 4'b0010, 3);
        show(7'h30, 4'b0100, 3);
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        chk("t7_rst_bcd", 32'(bcd_out), 32'h0);
        chk("t7_rst_fv", 32'(frame_valid), 32'h0);
        seg_in    = BLANK;
        digit_sel = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        scan4(7'h18, 7'h00, 7'h78, 7'h02);
        chk("t7_bcd", 32'(bcd_out), 32'h6789);
        chk("t7_fv_cnt", 32'(fv_cnt), 32'd7);
        chk("t7_fe", 32'(last_fe), 32'h0);
        chk("never_both", 32'(both), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
